// File: rtl/bennett_alu_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bennett_alu_scheduler
// Purpose  : Shares one Bennett-clocked adiabatic datapath between two
//            requesters. Arbitrates round-robin, latches operands, ramps the
//            stage clocks up (compute), samples the result at the plateau,
//            ramps them down in reverse (uncompute), then returns the result.
// Revision : 1.0 - initial release
// ============================================================================
module bennett_alu_scheduler #(
    parameter int WIDTH    = 16,
    parameter int OPW      = 2,
    parameter int STAGES   = 2,
    parameter int HOLD_CYC = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    input  logic [2*OPW-1:0]     req_op,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    output logic [OPW-1:0]       op_sel,
    output logic [STAGES-1:0]    clkp,
    output logic [STAGES-1:0]    clkn,
    input  logic [WIDTH-1:0]     dp_out,
    output logic                 resp_valid,
    output logic                 resp_id,
    output logic [WIDTH-1:0]     resp_data,
    output logic                 instFlag,
    output logic                 busy
);

    // Stage index and plateau counter widths; at least one bit each.
    localparam int c_k_width = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int c_h_width = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [c_k_width-1:0] c_k_last = c_k_width'(STAGES - 1);
    localparam logic [c_h_width-1:0] c_h_last = c_h_width'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COMPUTE   = 3'd1,
        S_HOLD      = 3'd2,
        S_UNCOMPUTE = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_k_width-1:0]    r_k;
    logic [c_h_width-1:0]    r_hold;
    logic                    r_prio;       // requester favoured on a tie
    logic [STAGES-1:0]       r_clkp;
    logic [WIDTH-1:0]        r_op_a;
    logic [WIDTH-1:0]        r_op_b;
    logic [OPW-1:0]          r_op_sel;
    logic                    r_resp_id;
    logic [WIDTH-1:0]        r_resp_data;
    logic [1:0]              w_grant;
    logic                    w_winner;
    logic                    w_accept;

    // Round-robin grant: a lone requester wins, a tie goes to r_prio.
    always_comb begin
        w_grant = req_valid;
        if (req_valid == 2'b11) begin
            w_grant = r_prio ? 2'b10 : 2'b01;
        end
        w_winner = w_grant[1];
    end

    assign w_accept  = (r_state == S_IDLE) && (req_valid != 2'b00);
    assign req_ready = (r_state == S_IDLE) ? w_grant : 2'b00;

    // Next-state sequencing of the Bennett cycle.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (r_k == c_k_last) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_hold == c_h_last) begin
                    w_state_next = S_UNCOMPUTE;
                end
            end
            S_UNCOMPUTE: begin
                if (r_k == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand latch, stage-clock ramp, plateau counter and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_k         <= '0;
            r_hold      <= '0;
            r_prio      <= 1'b0;
            r_clkp      <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_sel    <= '0;
            r_resp_id   <= 1'b0;
            r_resp_data <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        // Operands only move here, while every stage is down.
                        r_op_a    <= w_winner ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                        r_op_b    <= w_winner ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
                        r_op_sel  <= w_winner ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0];
                        r_resp_id <= w_winner;
                        r_prio    <= ~w_winner;
                        r_k       <= '0;
                        r_hold    <= '0;
                    end
                end
                S_COMPUTE: begin
                    // Raise one stage per edge, lowest first.
                    r_clkp[r_k] <= 1'b1;
                    if (r_k != c_k_last) begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_hold == c_h_last) begin
                        r_resp_data <= dp_out;
                        r_k         <= c_k_last;
                        r_hold      <= '0;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                S_UNCOMPUTE: begin
                    // Lower one stage per edge, highest first.
                    r_clkp[r_k] <= 1'b0;
                    if (r_k != '0) begin
                        r_k <= r_k - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign op_a       = r_op_a;
    assign op_b       = r_op_b;
    assign op_sel     = r_op_sel;
    assign clkp       = r_clkp;
    assign clkn       = ~r_clkp;
    assign resp_valid = (r_state == S_DONE);
    assign instFlag   = (r_state == S_DONE);
    assign resp_id    = r_resp_id;
    assign resp_data  = r_resp_data;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire
